// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding, constants and pattern step for the memory BIST
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } bist_state_e;

    // An all-zero seed would lock the pattern generator at zero forever.
    localparam logic [7:0] PAT_ZERO_SUB = 8'h01;

    function automatic logic [7:0] pat_next(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

endpackage

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - seeded write/read-back memory BIST sequencer with miscompare reporting
module mem_bist_ctrl
    import bist_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        lfsr_in,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W:0]   fail_cnt,
    output logic [ADDR_W-1:0] first_fail_addr
);

    bist_state_e       state_q, state_d;
    logic [7:0]        seed_q, seed_d;
    logic [7:0]        pat_q, pat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        exp_data_q, exp_data_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              exp_vld_q, exp_vld_d;
    logic              pass_q, pass_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [ADDR_W:0]   fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0] first_fail_q, first_fail_d;
    logic              run_clr;
    logic              miscmp;

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        pat_d        = pat_q;
        addr_d       = addr_q;
        exp_data_d   = exp_data_q;
        exp_addr_d   = exp_addr_q;
        exp_vld_d    = 1'b0;
        pass_d       = pass_q;
        run_clr      = 1'b0;

        miscmp       = exp_vld_q && (mem_rdata != exp_data_q);
        fail_valid_d = miscmp;
        fail_addr_d  = miscmp ? exp_addr_q : fail_addr_q;
        fail_cnt_d   = fail_cnt_q + {{ADDR_W{1'b0}}, miscmp};
        first_fail_d = (miscmp && fail_cnt_q == '0) ? exp_addr_q : first_fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEED;
                    pass_d  = 1'b0;
                    run_clr = 1'b1;
                end
            end
            ST_SEED: begin
                seed_d  = (lfsr_in == 8'h00) ? PAT_ZERO_SUB : lfsr_in;
                pat_d   = (lfsr_in == 8'h00) ? PAT_ZERO_SUB : lfsr_in;
                addr_d  = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                pat_d  = pat_next(pat_q);
                addr_d = addr_q + 1'b1;
                if (addr_q == '1) begin
                    pat_d   = seed_q;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                exp_vld_d  = 1'b1;
                exp_data_d = pat_q;
                exp_addr_d = addr_q;
                pat_d      = pat_next(pat_q);
                addr_d     = addr_q + 1'b1;
                if (addr_q == '1) begin
                    pat_d   = seed_q;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final compare resolves this cycle, so use the post-compare count.
                pass_d  = (fail_cnt_d == '0);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (run_clr) begin
            fail_cnt_d   = '0;
            first_fail_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            seed_q       <= '0;
            pat_q        <= '0;
            addr_q       <= '0;
            exp_data_q   <= '0;
            exp_addr_q   <= '0;
            exp_vld_q    <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            pat_q        <= pat_d;
            addr_q       <= addr_d;
            exp_data_q   <= exp_data_d;
            exp_addr_q   <= exp_addr_d;
            exp_vld_q    <= exp_vld_d;
            pass_q       <= pass_d;
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign mem_en          = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign mem_we          = (state_q == ST_WRITE);
    assign mem_addr        = mem_en ? addr_q : '0;
    assign mem_wdata       = mem_we ? pat_q : 8'h00;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign fail_valid      = fail_valid_q;
    assign fail_addr       = fail_addr_q;
    assign fail_cnt        = fail_cnt_q;
    assign first_fail_addr = first_fail_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb/tb_mem_bist_ctrl.sv - self-checking bench for mem_bist_ctrl with a faultable memory model
module tb_mem_bist_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        lfsr_in;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy, done, pass, fail_valid;
    logic [ADDR_W-1:0] fail_addr, first_fail_addr;
    logic [ADDR_W:0]   fail_cnt;

    mem_bist_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .lfsr_in(lfsr_in),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass),
        .fail_valid(fail_valid), .fail_addr(fail_addr),
        .fail_cnt(fail_cnt), .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // 0: clean, 1: bit0 stuck-at-0 at address 5, 2: reads return 0, 3: random XOR masks
    int         fault_mode;
    logic [7:0] flip_mask [DEPTH];
    logic [7:0] mem [DEPTH];

    function automatic logic [7:0] fault_read(input int a, input logic [7:0] v);
        case (fault_mode)
            1:       return (a == 5) ? (v & 8'hFE) : v;
            2:       return 8'h00;
            3:       return v ^ flip_mask[a];
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= fault_read(int'(mem_addr), mem[mem_addr]);
        end
    end

    typedef struct {
        int addr;
        int data;
        int cyc;
    } ev_t;

    ev_t wq[$];
    ev_t fq[$];
    int  dq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pattern: 8-bit shift left with feedback = parity of taps 7,5,4,3.
    function automatic void ref_patterns(input logic [7:0] sd, output logic [7:0] p [DEPTH]);
        logic [7:0] v;
        v = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < DEPTH; i++) begin
            p[i] = v;
            v = ((v << 1) & 8'hFE) | {7'd0, ^(v & 8'hB8)};
        end
    endfunction

    task automatic run(input logic [7:0] sd, input int pulse_c, input bit hold_end, input int len);
        wq.delete(); fq.delete(); dq.delete();
        @(negedge clk);
        start   = 1'b1;
        lfsr_in = 8'($urandom);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            start   = (c == pulse_c) || (hold_end && (c == 35 || c == 36));
            lfsr_in = (c == 1) ? sd : 8'($urandom);
            if (mem_en && mem_we) wq.push_back('{int'(mem_addr), int'(mem_wdata), c});
            if (fail_valid)       fq.push_back('{int'(fail_addr), 0, c});
            if (done)             dq.push_back(c);
        end
        start = 1'b0;
    endtask

    task automatic check_run(input logic [7:0] sd, input string tag);
        logic [7:0] p [DEPTH];
        int exp_f[$];
        int errs;
        ref_patterns(sd, p);
        for (int i = 0; i < DEPTH; i++)
            if (fault_read(i, p[i]) != p[i]) exp_f.push_back(i);
        chk({tag, " write_count"}, wq.size(), DEPTH);
        errs = 0;
        foreach (wq[i])
            if (wq[i].addr != i || wq[i].data != int'(p[i % DEPTH]) || wq[i].cyc != i + 2) errs++;
        chk({tag, " write_seq"}, errs, 0);
        chk({tag, " fail_events"}, fq.size(), exp_f.size());
        errs = 0;
        foreach (fq[i])
            if (i >= exp_f.size() || fq[i].addr != exp_f[i] || fq[i].cyc != DEPTH + 4 + exp_f[i]) errs++;
        chk({tag, " fail_seq"}, errs, 0);
        chk({tag, " done_single"}, (dq.size() == 1) ? dq[0] : -1, 2 * DEPTH + 3);
        chk({tag, " pass"}, pass, (exp_f.size() == 0));
        chk({tag, " fail_cnt"}, fail_cnt, exp_f.size());
        chk({tag, " first_fail"}, first_fail_addr, (exp_f.size() != 0) ? exp_f[0] : 0);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] sd;
        int         mode;
        bit         e_pass;
        int         e_cnt;
        int         e_first;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'hA5, 0, 1'b1, 0, 0};
        vecs[1] = '{8'h00, 0, 1'b1, 0, 0};
        vecs[2] = '{8'hA5, 1, 1'b0, 1, 5};
        vecs[3] = '{8'hA5, 2, 1'b0, 16, 0};

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]       = 8'($urandom);
            flip_mask[i] = 8'h00;
        end
        fault_mode = 0;
        mem_rdata  = 8'h00;
        rst = 1'b1; start = 1'b0; lfsr_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {mem_en, mem_we, mem_addr, mem_wdata, busy, done, pass,
                              fail_valid, fail_addr, fail_cnt, first_fail_addr}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        foreach (vecs[v]) begin
            fault_mode = vecs[v].mode;
            run(vecs[v].sd, 0, 1'b0, 38);
            check_run(vecs[v].sd, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d tbl_pass", v), pass, vecs[v].e_pass);
            chk($sformatf("vec%0d tbl_cnt", v), fail_cnt, vecs[v].e_cnt);
            chk($sformatf("vec%0d tbl_first", v), first_fail_addr, vecs[v].e_first);
            if (v == 1) chk("zero_seed_words", (wq.size() >= 2) ? {wq[0].data[7:0], wq[1].data[7:0]} : 0, 16'h0102);
            if (v == 3) chk("last_fail_with_done", (fq.size() != 0) ? fq[fq.size()-1].cyc : -1, 35);
        end

        fault_mode = 0;
        run(8'h3C, 6, 1'b0, 38);
        check_run(8'h3C, "start_in_write");

        for (int r = 0; r < 8; r++) begin
            logic [7:0] sd;
            sd = 8'($urandom);
            fault_mode = $urandom_range(0, 3);
            for (int i = 0; i < DEPTH; i++)
                flip_mask[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run(sd, 0, 1'b0, 38);
            check_run(sd, $sformatf("rand%0d", r));
        end

        fault_mode = 0;
        @(negedge clk);
        start   = 1'b1;
        lfsr_in = 8'h77;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_writing", mem_en && mem_we, 1);
        rst = 1'b1;
        #1;
        chk("reset_midrun_outputs", {mem_en, mem_we, mem_addr, mem_wdata, busy, done, pass,
                                     fail_valid, fail_addr, fail_cnt, first_fail_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(8'h81, 0, 1'b0, 38);
        check_run(8'h81, "after_reset");

        run(8'h5A, 0, 1'b1, 72);
        chk("held_start_done_count", dq.size(), 2);
        chk("held_start_done2", (dq.size() == 2) ? dq[1] : -1, 71);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
